// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared D$ request/response types and arbiter port-ID type
package ariane_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned DCACHE_DATA_WIDTH  = 64;

  // Requesters sharing the D$ port: 0 = PTW, 1 = load unit, 2 = store buffer
  localparam int unsigned DCACHE_ARB_PORTS = 3;

  typedef logic [$clog2(DCACHE_ARB_PORTS)-1:0] dcache_arb_id_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0]  address_index;
    logic [DCACHE_TAG_WIDTH-1:0]    address_tag;
    logic [DCACHE_DATA_WIDTH-1:0]   data_wdata;
    logic                           data_req;
    logic                           data_we;
    logic [DCACHE_DATA_WIDTH/8-1:0] data_be;
    logic [1:0]                     data_size;
    logic                           kill_req;
    logic                           tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order FIFO of granted read port IDs
module arb_id_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  dcache_arb_id_t data_i,
  input  logic           pop_i,
  output dcache_arb_id_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  dcache_arb_id_t   mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - shares one D$ port among requesters, routes read data back (DCACHE_ARB_FIXED_PRIO_EN selects fixed priority)
module dcache_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS      = DCACHE_ARB_PORTS,
  parameter int unsigned ID_FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_ports_i [NR_PORTS],
  output dcache_req_o_t req_ports_o [NR_PORTS],
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_req_i
);

  logic [NR_PORTS-1:0] elig;
  dcache_arb_id_t      sel, search_base, head_id;
  logic                sel_valid, gnt, push, pop;
  logic                fifo_full, fifo_empty;
  logic                lock_q, lock_d;
  dcache_arb_id_t      lock_id_q, lock_id_d;
  logic                tag_own_q, tag_own_d;
  dcache_arb_id_t      tag_id_q, tag_id_d;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  dcache_arb_id_t rr_ptr_q, rr_ptr_d;
  assign search_base = rr_ptr_q;
`endif

  // Reads need a free ID slot; writes never return data so they always qualify
  always_comb begin
    elig = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      elig[i] = req_ports_i[i].data_req & (req_ports_i[i].data_we | ~fifo_full);
    end
  end

  // Locked port holds the selection until granted; otherwise first eligible from search_base
  always_comb begin
    sel       = lock_id_q;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel_valid = elig[lock_id_q];
    end else begin
      for (int k = 0; k < NR_PORTS; k++) begin
        automatic dcache_arb_id_t cand = dcache_arb_id_t'((int'(search_base) + k) % NR_PORTS);
        if (!sel_valid && elig[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign gnt  = sel_valid & cache_req_i.data_gnt;
  assign push = gnt & ~req_ports_i[sel].data_we;
  assign pop  = cache_req_i.data_rvalid & ~fifo_empty;

  // Mux the selected request; tag fields belong to last cycle's read while it owns the tag phase
  always_comb begin
    cache_req_o          = req_ports_i[sel];
    cache_req_o.data_req = sel_valid;
    if (tag_own_q) begin
      cache_req_o.address_tag = req_ports_i[tag_id_q].address_tag;
      cache_req_o.tag_valid   = req_ports_i[tag_id_q].tag_valid;
      cache_req_o.kill_req    = req_ports_i[tag_id_q].kill_req;
    end else begin
      cache_req_o.tag_valid   = sel_valid & req_ports_i[sel].tag_valid;
      cache_req_o.kill_req    = sel_valid & req_ports_i[sel].kill_req;
    end
  end

  // Grant goes to the selected port only; rvalid goes to the oldest outstanding reader
  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) begin
      req_ports_o[i].data_gnt    = gnt & (sel == dcache_arb_id_t'(i));
      req_ports_o[i].data_rvalid = pop & (head_id == dcache_arb_id_t'(i));
      req_ports_o[i].data_rdata  = cache_req_i.data_rdata;
    end
  end

  // Next-state for lock, tag ownership and round-robin pointer
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (gnt) begin
      lock_d = 1'b0;
    end else if (sel_valid) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    tag_own_d = push;
    tag_id_d  = sel;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
    if (gnt) begin
      rr_ptr_d = (sel == dcache_arb_id_t'(NR_PORTS - 1)) ? '0 : sel + dcache_arb_id_t'(1);
    end
`endif
  end

  // Arbiter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      tag_own_q <= 1'b0;
      tag_id_q  <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      tag_own_q <= tag_own_d;
      tag_id_q  <= tag_id_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  arb_id_fifo #(
    .DEPTH (ID_FIFO_DEPTH)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding means the D$ and arbiter disagree
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(cache_req_i.data_rvalid && fifo_empty))
        else $error("dcache_port_arbiter: rvalid with no outstanding read");
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - randomized scoreboard bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
  import ariane_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  dcache_req_i_t req_i [NP];
  dcache_req_o_t req_o [NP];
  dcache_req_i_t c_o;
  dcache_req_o_t c_i;

  dcache_port_arbiter #(
    .NR_PORTS      (NP),
    .ID_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_ports_i (req_i),
    .req_ports_o (req_o),
    .cache_req_o (c_o),
    .cache_req_i (c_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit [NP-1:0] gnt;
    logic [11:0] idx;
    logic [63:0] wdata;
    bit          we;
    logic [7:0]  be;
    logic [1:0]  size;
    bit          tag_chk;
    logic [43:0] tag;
    bit          tv;
    bit          kill;
    bit          rv;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q [$];
  int   rd_q  [$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: requester bookkeeping and arbiter-level behaviour
  bit            pend [NP];
  dcache_req_i_t cur  [NP];
  int            m_rr, m_lock, m_lock_id, m_tag_own, m_tag_id, m_out;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected record per active cycle, read data matched to grant order
  exp_t        mon_e;
  logic [NP-1:0] mon_gv, mon_rv;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int p = 0; p < NP; p++) begin
        mon_gv[p] = req_o[p].data_gnt;
        mon_rv[p] = req_o[p].data_rvalid;
      end
      chk("data_req", 64'(c_o.data_req), 64'(mon_e.req));
      chk("gnt_vec", 64'(mon_gv), 64'(mon_e.gnt));
      if (mon_e.req) begin
        chk("index", 64'(c_o.address_index), 64'(mon_e.idx));
        chk("wdata", c_o.data_wdata, mon_e.wdata);
        chk("we", 64'(c_o.data_we), 64'(mon_e.we));
        chk("be", 64'(c_o.data_be), 64'(mon_e.be));
        chk("size", 64'(c_o.data_size), 64'(mon_e.size));
      end
      if (mon_e.tag_chk) chk("address_tag", 64'(c_o.address_tag), 64'(mon_e.tag));
      chk("tag_valid", 64'(c_o.tag_valid), 64'(mon_e.tv));
      chk("kill_req", 64'(c_o.kill_req), 64'(mon_e.kill));
      chk("rvalid_any", 64'(|mon_rv), 64'(mon_e.rv));
      for (int p = 0; p < NP; p++) begin
        if (mon_rv[p]) begin
          if (rd_q.size() == 0) begin
            chk("rvalid_unexpected_port", 64'(p), 64'hffff);
          end else begin
            chk("rvalid_port", 64'(p), 64'(rd_q.pop_front()));
          end
          chk("rdata", req_o[p].data_rdata, mon_e.rdata);
        end
      end
    end
  end

  // Drive one cycle of stimulus, predict outputs, then advance the reference after the edge
  task automatic do_cycle(int p_new, int p_gnt, int p_rv, bit allow_new);
    bit [NP-1:0] elig;
    int          sel, best, d, ts;
    bit          valid, gnt, rd;
    exp_t        e;
    for (int i = 0; i < NP; i++) begin
      if (!pend[i] && allow_new && $urandom_range(99) < p_new) begin
        pend[i]              = 1'b1;
        cur[i].address_index = 12'($urandom);
        cur[i].data_wdata    = {$urandom, $urandom};
        cur[i].data_we       = 1'($urandom_range(1));
        cur[i].data_be       = 8'($urandom);
        cur[i].data_size     = 2'($urandom);
      end
      req_i[i]             = cur[i];
      req_i[i].data_req    = pend[i];
      req_i[i].address_tag = 44'({$urandom, $urandom});
      req_i[i].tag_valid   = 1'($urandom_range(1));
      req_i[i].kill_req    = ($urandom_range(7) == 0);
    end
    c_i.data_gnt    = ($urandom_range(99) < p_gnt);
    c_i.data_rvalid = (m_out > 0) && ($urandom_range(99) < p_rv);
    c_i.data_rdata  = {$urandom, $urandom};

    for (int i = 0; i < NP; i++)
      elig[i] = req_i[i].data_req && (req_i[i].data_we || m_out < DEPTH);
    valid = 1'b0;
    sel   = 0;
    if (m_lock != 0) begin
      sel   = m_lock_id;
      valid = elig[sel];
    end else begin
      best = NP;
      for (int i = 0; i < NP; i++) begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
        d = i;
`else
        d = (i - m_rr + NP) % NP;
`endif
        if (elig[i] && d < best) begin
          best  = d;
          sel   = i;
          valid = 1'b1;
        end
      end
    end
    gnt = valid && c_i.data_gnt;
    rd  = valid && !req_i[sel].data_we;

    e.req   = valid;
    e.gnt   = '0;
    if (gnt) e.gnt[sel] = 1'b1;
    e.idx   = req_i[sel].address_index;
    e.wdata = req_i[sel].data_wdata;
    e.we    = req_i[sel].data_we;
    e.be    = req_i[sel].data_be;
    e.size  = req_i[sel].data_size;
    ts        = (m_tag_own != 0) ? m_tag_id : sel;
    e.tag_chk = (m_tag_own != 0) || valid;
    e.tag     = req_i[ts].address_tag;
    e.tv      = e.tag_chk && req_i[ts].tag_valid;
    e.kill    = e.tag_chk && req_i[ts].kill_req;
    e.rv      = c_i.data_rvalid;
    e.rdata   = c_i.data_rdata;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    m_tag_own = 0;
    if (gnt) begin
      pend[sel] = 1'b0;
      m_rr      = (sel + 1) % NP;
      m_lock    = 0;
      if (rd) begin
        rd_q.push_back(sel);
        m_out++;
        m_tag_own = 1;
        m_tag_id  = sel;
      end
    end else if (valid) begin
      m_lock    = 1;
      m_lock_id = sel;
    end
    if (e.rv) m_out--;
  endtask

  // Asynchronous reset with idle inputs; checks reset outputs and clears the reference
  task automatic do_reset();
    for (int i = 0; i < NP; i++) req_i[i] = '0;
    c_i   = '0;
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NP; i++) begin
      chk("reset_gnt", 64'(req_o[i].data_gnt), 64'd0);
      chk("reset_rvalid", 64'(req_o[i].data_rvalid), 64'd0);
    end
    chk("reset_data_req", 64'(c_o.data_req), 64'd0);
    chk("reset_tag_valid", 64'(c_o.tag_valid), 64'd0);
    chk("reset_kill_req", 64'(c_o.kill_req), 64'd0);
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0;
      cur[i]  = '0;
    end
    m_rr = 0; m_lock = 0; m_lock_id = 0; m_tag_own = 0; m_tag_id = 0; m_out = 0;
    rd_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit busy;
    do_reset();
    repeat (300) do_cycle(40, 60, 40, 1'b1);
    repeat (200) do_cycle(70, 50, 5, 1'b1);
    repeat (100) do_cycle(50, 20, 30, 1'b1);
    repeat (60)  do_cycle(60, 70, 5, 1'b1);
    do_reset();
    repeat (300) do_cycle(45, 60, 35, 1'b1);
    n    = 0;
    busy = 1'b1;
    while (busy && n < 100) begin
      do_cycle(0, 100, 100, 1'b0);
      n++;
      busy = (m_out > 0) || pend[0] || pend[1] || pend[2];
    end
    @(negedge clk);
    #1;
    chk("drain_within_bound", 64'(busy), 64'd0);
    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
